// File: rtl/rom_scan_reader_if.sv
// Downstream stream bundle for rom_scan_reader: the captured word, the ROM address
// it came from, and the valid/ready handshake.
interface rom_scan_reader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_W-1:0]   out_addr;
    logic [4*DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/rom_scan_reader.sv
// Burst read initiator for the 4-lane ROM: issues sequential reads, captures each word
// after READ_LAT cycles and presents it downstream. Optional burst checksum: ROM_SCAN_CHECKSUM_EN.
module rom_scan_reader #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W:0]      count,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_address,
    output logic                 rom_read_en,
    output logic                 rom_ce,
    input  logic [DATA_W-1:0]    rom_data_F1,
    input  logic [DATA_W-1:0]    rom_data_F2,
    input  logic [DATA_W-1:0]    rom_data_F3,
    input  logic [DATA_W-1:0]    rom_data_F4,
    rom_scan_reader_if.master    stream,
    output logic [DATA_W-1:0]    checksum
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT
    } state_t;

    localparam logic [ADDR_W:0] FULL_BURST = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [1:0]      LAT_LOAD   = 2'(READ_LAT - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W:0]     remaining;
    logic [1:0]          lat_cnt;
    logic                valid_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [4*DATA_W-1:0] out_data_q;
    logic [4*DATA_W-1:0] lanes;
    logic                capture;
    logic                handshake;

    assign lanes     = {rom_data_F4, rom_data_F3, rom_data_F2, rom_data_F1};
    // Capture happens at the end of the last cycle the ROM is enabled.
    assign capture   = ((state == ISSUE) && (READ_LAT == 1)) ||
                       ((state == WAIT) && (lat_cnt == 2'd1));
    assign handshake = (state == PRESENT) && valid_q && stream.out_ready;

    assign rom_address      = addr_cnt;
    assign stream.out_valid = valid_q;
    assign stream.out_addr  = out_addr_q;
    assign stream.out_data  = out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            remaining   <= '0;
            lat_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_ce      <= 1'b0;
            rom_read_en <= 1'b0;
            valid_q     <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_cnt    <= start_addr;
                        remaining   <= (count == '0) ? FULL_BURST : count;
                        busy        <= 1'b1;
                        rom_ce      <= 1'b1;
                        rom_read_en <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
                PRESENT: begin
                    if (handshake) begin
                        valid_q   <= 1'b0;
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rom_ce      <= 1'b1;
                            rom_read_en <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the ISSUE/WAIT next-state when the read latency has elapsed.
            if (capture) begin
                out_data_q  <= lanes;
                out_addr_q  <= addr_cnt;
                valid_q     <= 1'b1;
                rom_ce      <= 1'b0;
                rom_read_en <= 1'b0;
                state       <= PRESENT;
            end
        end
    end

`ifdef ROM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
    logic [DATA_W-1:0] beat_sum;

    assign beat_sum = out_data_q[DATA_W-1:0] + out_data_q[2*DATA_W-1:DATA_W] +
                      out_data_q[3*DATA_W-1:2*DATA_W] + out_data_q[4*DATA_W-1:3*DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if ((state == IDLE) && start) begin
            csum_q <= '0;
        end else if (handshake) begin
            csum_q <= csum_q + beat_sum;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule
